// File: rtl/bandit_pkg.sv
// bandit_pkg: shared widths, data types and episode states for the bandit environment.
package bandit_pkg;
  localparam int DEF_ACTION_WIDTH = 8;
  localparam int DEF_REWARD_WIDTH = 8;
  typedef logic [DEF_ACTION_WIDTH-1:0] action_t;
  typedef logic signed [DEF_REWARD_WIDTH-1:0] reward_t;
  typedef enum logic [2:0] {CLEAR, IDLE, WAIT_ACTION, LOOKUP, REWARD, DONE} episode_state_t;
endpackage

// File: rtl/bandit_reward_table.sv
// bandit_reward_table: reward memory with one write port and a registered, resettable read port.
module bandit_reward_table
  import bandit_pkg::*;
#(
  parameter int ACTION_WIDTH = DEF_ACTION_WIDTH,
  parameter int REWARD_WIDTH = DEF_REWARD_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ACTION_WIDTH-1:0] waddr,
  input  logic [REWARD_WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [ACTION_WIDTH-1:0] raddr,
  output logic [REWARD_WIDTH-1:0] rdata
);
  logic [REWARD_WIDTH-1:0] mem [2**ACTION_WIDTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  // the read register doubles as the held reward, so it is only loaded on a lookup
  always_ff @(posedge clock or posedge reset)
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/bandit_episode.sv
// bandit_episode: runs N-trial episodes, returning table rewards to the core and tallying them.
// Define BANDIT_EPISODE_POSITIVE_EN to build the positive-reward counter.
module bandit_episode
  import bandit_pkg::*;
#(
  parameter int ACTION_WIDTH = DEF_ACTION_WIDTH,
  parameter int REWARD_WIDTH = DEF_REWARD_WIDTH,
  parameter int STEP_WIDTH   = 16,
  parameter int TOTAL_WIDTH  = 24
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [ACTION_WIDTH-1:0] cfg_addr,
  input  logic [REWARD_WIDTH-1:0] cfg_data,
  output logic                    cfg_ready,
  input  logic                    start,
  input  logic [STEP_WIDTH-1:0]   steps,
  output logic                    busy,
  output logic                    done,
  input  logic                    action_valid,
  input  logic [ACTION_WIDTH-1:0] action_data,
  output logic                    action_ready,
  output logic                    reward_valid,
  output logic [REWARD_WIDTH-1:0] reward_data,
  input  logic                    reward_ready,
  output logic [STEP_WIDTH-1:0]   step_count,
  output logic [TOTAL_WIDTH-1:0]  total_reward,
  output logic [STEP_WIDTH-1:0]   positive_count
);
  localparam logic [TOTAL_WIDTH-1:0] T_MAX = {1'b0, {(TOTAL_WIDTH-1){1'b1}}};
  localparam logic [TOTAL_WIDTH-1:0] T_MIN = {1'b1, {(TOTAL_WIDTH-1){1'b0}}};
  episode_state_t state, state_n;
  logic [ACTION_WIDTH-1:0] clear_addr, action;
  logic [STEP_WIDTH-1:0] steps_q;
  logic [TOTAL_WIDTH:0] sum;
  logic [TOTAL_WIDTH-1:0] sat;
  logic start_ok, fire, last, clearing;
  assign clearing = state == CLEAR;
  assign start_ok = state == IDLE && start;
  assign fire = state == REWARD && reward_ready;
  assign last = step_count + STEP_WIDTH'(1) == steps_q;
  // one guard bit catches overflow of the signed accumulation
  assign sum = {total_reward[TOTAL_WIDTH-1], total_reward}
             + {{(TOTAL_WIDTH+1-REWARD_WIDTH){reward_data[REWARD_WIDTH-1]}}, reward_data};
  assign sat = sum[TOTAL_WIDTH] != sum[TOTAL_WIDTH-1] ? (sum[TOTAL_WIDTH] ? T_MIN : T_MAX)
             : sum[TOTAL_WIDTH-1:0];
  bandit_reward_table #(.ACTION_WIDTH(ACTION_WIDTH), .REWARD_WIDTH(REWARD_WIDTH)) table_i (
    .clock(clock),
    .reset(reset),
    .we(clearing || (state == IDLE && cfg_we)),
    .waddr(clearing ? clear_addr : cfg_addr),
    .wdata(clearing ? '0 : cfg_data),
    .re(state == LOOKUP),
    .raddr(action),
    .rdata(reward_data)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      CLEAR:       state_n = clear_addr == '1 ? IDLE : CLEAR;
      IDLE:        state_n = start ? (steps == '0 ? DONE : WAIT_ACTION) : IDLE;
      WAIT_ACTION: state_n = action_valid ? LOOKUP : WAIT_ACTION;
      LOOKUP:      state_n = REWARD;
      REWARD:      state_n = reward_ready ? (last ? DONE : WAIT_ACTION) : REWARD;
      DONE:        state_n = IDLE;
      default:     state_n = CLEAR;
    endcase
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      busy <= 1'b1;
      cfg_ready <= 1'b0;
      done <= 1'b0;
      action_ready <= 1'b0;
      reward_valid <= 1'b0;
      step_count <= '0;
      total_reward <= '0;
      clear_addr <= '0;
      steps_q <= '0;
      action <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      cfg_ready <= state_n == IDLE;
      done <= state_n == DONE;
      action_ready <= state_n == WAIT_ACTION;
      reward_valid <= state_n == REWARD;
      if (clearing) clear_addr <= clear_addr + ACTION_WIDTH'(1);
      if (start_ok) begin
        steps_q <= steps;
        step_count <= '0;
        total_reward <= '0;
      end
      if (state == WAIT_ACTION && action_valid) action <= action_data;
      if (fire) begin
        step_count <= step_count + STEP_WIDTH'(1);
        total_reward <= sat;
      end
    end
  end
`ifdef BANDIT_EPISODE_POSITIVE_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) positive_count <= '0;
    else if (start_ok) positive_count <= '0;
    else if (fire && !reward_data[REWARD_WIDTH-1] && |reward_data && positive_count != '1)
      positive_count <= positive_count + STEP_WIDTH'(1);
`else
  assign positive_count = '0;
`endif
endmodule

// File: tb/tb_bandit_episode.sv
// tb_bandit_episode: table vectors plus reward scoreboard for bandit_episode.
module tb_bandit_episode;
  localparam int TW = 12;
  localparam int TMAX = (1 << (TW - 1)) - 1;
  localparam int TMIN = -(1 << (TW - 1));
  typedef struct {int addr; int data; int n; int exp_total;} vec_t;
  logic clock = 0, reset = 1, cfg_we = 0, start = 0, action_valid = 0, reward_ready = 0;
  logic [7:0] cfg_addr = 0, cfg_data = 0, action_data = 0;
  logic [15:0] steps = 0;
  logic cfg_ready, busy, done, action_ready, reward_valid;
  logic [7:0] reward_data;
  logic [15:0] step_count, positive_count;
  logic [TW-1:0] total_reward;
  int total = 0, bad = 0, overlap = 0;
  int model [256];
  int exp_q [$];
  int m_total, m_steps, m_pos;
  vec_t vecs [6];

  bandit_episode #(.TOTAL_WIDTH(TW)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .start(start), .steps(steps), .busy(busy), .done(done),
    .action_valid(action_valid), .action_data(action_data), .action_ready(action_ready),
    .reward_valid(reward_valid), .reward_data(reward_data), .reward_ready(reward_ready),
    .step_count(step_count), .total_reward(total_reward), .positive_count(positive_count)
  );

  always #5 clock = ~clock;
  always @(negedge clock) if (action_ready && reward_valid) overlap++;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_busy", busy, 1);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_done", done, 0);
    check("rst_action_ready", action_ready, 0);
    check("rst_reward_valid", reward_valid, 0);
    check("rst_reward_data", reward_data, 0);
    check("rst_step_count", step_count, 0);
    check("rst_total", total_reward, 0);
    check("rst_positive", positive_count, 0);
  endtask

  task automatic wait_clear();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("clear_cycles", n, 256);
    check("cfg_ready_after_clear", cfg_ready, 1);
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clock);
    cfg_we = 1; cfg_addr = a[7:0]; cfg_data = d[7:0];
    @(negedge clock);
    cfg_we = 0;
    model[a] = d;
  endtask

  task automatic start_ep(input int n);
    @(negedge clock);
    start = 1; steps = n[15:0];
    @(negedge clock);
    start = 0;
    m_total = 0; m_steps = 0; m_pos = 0;
  endtask

  task automatic do_step(input int a, input int stall);
    int t = 0;
    int e;
    @(negedge clock);
    action_valid = 1; action_data = a[7:0];
    while (!action_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) check("action_ready_timeout", action_ready, 1);
    exp_q.push_back(model[a]);
    @(negedge clock);
    action_valid = 0;
    check("lookup_no_valid", reward_valid, 0);
    check("lookup_no_ready", action_ready, 0);
    @(negedge clock);
    check("reward_latency", reward_valid, 1);
    for (int k = 0; k < stall; k++) begin
      @(negedge clock);
      check("stall_valid", reward_valid, 1);
      check("stall_data", $signed(reward_data), model[a]);
      check("stall_steps", step_count, m_steps);
    end
    e = exp_q.pop_front();
    check("reward_data", $signed(reward_data), e);
    reward_ready = 1;
    m_total += e;
    m_total = m_total > TMAX ? TMAX : m_total < TMIN ? TMIN : m_total;
    m_steps++;
    if (e > 0) m_pos++;
    @(negedge clock);
    reward_ready = 0;
    check("reward_valid_drop", reward_valid, 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 20) begin
      @(negedge clock);
      t++;
    end
    check("done_seen", done, 1);
    @(negedge clock);
    check("done_pulse", done, 0);
    check("idle_cfg_ready", cfg_ready, 1);
    check("step_count", step_count, m_steps);
    check("total_reward", $signed(total_reward), m_total);
`ifdef BANDIT_EPISODE_POSITIVE_EN
    check("positive_count", positive_count, m_pos);
`else
    check("positive_count", positive_count, 0);
`endif
  endtask

  initial begin
    vecs[0] = '{30, 3, 1, 3};
    vecs[1] = '{31, -2, 3, -6};
    vecs[2] = '{32, 127, 20, 2047};
    vecs[3] = '{33, -128, 20, -2048};
    vecs[4] = '{34, 100, 5, 500};
    vecs[5] = '{35, 0, 4, 0};
    for (int i = 0; i < 256; i++) model[i] = 0;
    #12;
    check_reset();
    @(negedge clock);
    reset = 0;
    wait_clear();
    for (int a = 0; a < 256; a++) begin
      start_ep(1);
      do_step(a, 0);
      wait_done();
    end
    wr(64, 3);
    start_ep(1);
    do_step(64, 0);
    wait_done();
    check("single_total", $signed(total_reward), 3);
    for (int v = 0; v < 6; v++) begin
      wr(vecs[v].addr, vecs[v].data);
      start_ep(vecs[v].n);
      for (int s = 0; s < vecs[v].n; s++) do_step(vecs[v].addr, 0);
      wait_done();
      check("vec_total", $signed(total_reward), vecs[v].exp_total);
    end
    wr(5, -2);
    start_ep(100);
    for (int i = 0; i < 100; i++) do_step(i < 40 ? 64 : i < 50 ? 5 : 7 + i % 3, 0);
    wait_done();
    check("run100_steps", step_count, 100);
    check("run100_total", $signed(total_reward), 100);
`ifdef BANDIT_EPISODE_POSITIVE_EN
    check("run100_positive", positive_count, 40);
`else
    check("run100_positive", positive_count, 0);
`endif
    start_ep(0);
    check("zero_no_action_ready", action_ready, 0);
    check("zero_no_reward_valid", reward_valid, 0);
    wait_done();
    check("zero_step_count", step_count, 0);
    start_ep(1);
    do_step(64, 20);
    wait_done();
    @(negedge clock);
    cfg_we = 1; cfg_addr = 20; cfg_data = 9; start = 1; steps = 1;
    @(negedge clock);
    cfg_we = 0; start = 0;
    model[20] = 9; m_total = 0; m_steps = 0; m_pos = 0;
    do_step(20, 0);
    wait_done();
    wr(0, 127);
    start_ep(5);
    do_step(0, 0);
    @(negedge clock);
    action_valid = 1; action_data = 0;
    @(negedge clock);
    action_valid = 0;
    #2 reset = 1;
    #1;
    check_reset();
    exp_q.delete();
    for (int i = 0; i < 256; i++) model[i] = 0;
    @(negedge clock);
    reset = 0;
    wait_clear();
    start_ep(1);
    do_step(0, 0);
    wait_done();
    check("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
